serve_counters: RTL and testbench
=================================

# serve_counters

Owns the two serving-window spaces in front of the order/points logic. Accepts item drops from the two players, runs a per-space state machine (empty → plate → finished dish), and presents each space's contents as a 4-bit code on `check_spaces`. The downstream scorer consumes that code and pulses `clear_space` when it books a delivery. Stale dishes and, optionally, wrong items are handled locally.

## Interface
- `STALE_FRAMES`, default 600: frames a finished dish may sit uncleared before it is discarded.
- `REJECT_FRAMES`, default 30: frames a rejected item stays displayed (only with `SERVE_REJECT_EN`).
- `vsync` in 1: frame clock. All state changes on the negedge, like the rest of the game logic.
- `reset_n` in 1: synchronous, active-low reset.
- `game_state` in 3: `0` = menu. Treated exactly like reset.
- `place_valid` in [1:0]: player p requests a drop this frame.
- `place_space` in [1:0]: target space for player p (`0` or `1`).
- `place_item` in [1:0][3:0]: item carried by player p.
- `clear_space` in [1:0]: scorer consumed the dish on space i.
- `check_spaces` out [1:0][3:0]: contents code per space.
- `place_ack` out [1:0]: one-frame pulse; player p's drop was taken and p must empty its hands.
- `stale` out [1:0]: one-frame pulse; the dish on space i was discarded uncollected.

## Operation
- Item codes: `0` none, `1` clean plate, `2` pot of soup, `4` plated soup. Any other nonzero code is invalid.
- Each space has an FSM with states EMPTY, PLATE, DISH, REJECT. `check_spaces` is decoded from state: `0`, `1`, `4`, `4'hF`.
- EMPTY:
  - item 1 → PLATE.
  - item 4 → DISH.
  - item 2 → ignored, no ack.
  - invalid item → REJECT when the macro is defined; otherwise ignored, no ack.
- PLATE: item 2 → DISH. Every other item is ignored.
- DISH: accepts nothing.
  - `clear_space[i]` → EMPTY.
  - Held `STALE_FRAMES` frames without a clear → EMPTY and pulse `stale[i]`.
- REJECT: accepts nothing. After `REJECT_FRAMES` frames → EMPTY. `clear_space` is ignored.
- `clear_space[i]` in any state other than DISH is ignored.
- Arbitration: if both players target the same space in the same frame, player 0 is evaluated first. Player 1 is then evaluated against the unchanged current state and is never acked for that space that frame.
  - Players targeting different spaces are both serviced.
- When `clear_space[i]` and a drop on space i arrive together, the clear wins and the drop is not acked.
- Per-space 10-bit frame counter: zeroed on every state entry, incremented while in DISH or REJECT. It never wraps, because the exit fires at `count == limit-1`.

## Timing
- Reset (`reset_n=0` or `game_state==0`, synchronous):
  - All spaces go to EMPTY and all counters to 0.
  - `check_spaces=0`, `place_ack=0`, `stale=0` from the next negedge.
  - Reset mid-dish discards the dish silently, with no `stale` pulse.
- A drop sampled on edge k updates `check_spaces` and pulses `place_ack` after edge k. Both are registered, so there is one frame of latency.
- A DISH entered on edge k is visible to the scorer at edge k+1. The scorer's `clear_space` is seen at edge k+2, and the space reads `0` after edge k+2.
- A DISH entered on edge k and never cleared leaves DISH after edge k+`STALE_FRAMES`, with `stale` high for that one frame.
- `place_ack` and `stale` are high for exactly one frame per event.

## Configuration
- Macro `SERVE_REJECT_EN`.
- Defined: invalid items dropped on an EMPTY space are acked and shown as `4'hF` for `REJECT_FRAMES` frames.
- Undefined:
  - The REJECT state and its counter path are not compiled.
  - Invalid drops are never acked.
  - `check_spaces` never shows `4'hF`.

## Test plan
- After reset, player 0 drops item 1 then item 2 on space 0:
  - `check_spaces[0]` goes 0 → 1 → 4.
  - `place_ack[0]` pulses on both drops.
  - `clear_space[0]` one frame later returns it to 0.
- Both players drop item 4 on space 1 in the same frame:
  - Only `place_ack[0]` pulses and `check_spaces[1]=4`.
  - Player 1 retries on space 0 next frame and is acked.
- Item 4 on space 0 with no clear for 600 frames:
  - `stale[0]` pulses on frame 600 and `check_spaces[0]` returns to 0.
  - Pulsing `clear_space[0]` at frame 599 instead → no stale pulse.
- Drop item 4 on a DISH space together with `clear_space` → space goes EMPTY and there is no ack.
- With `SERVE_REJECT_EN`, drop item 7 on EMPTY space 0:
  - Ack pulses and `check_spaces[0]=4'hF` for 30 frames, then 0.
  - Without the macro: no ack and the space stays 0.
- `game_state` forced to 0 while space 1 is DISH → all outputs 0 next frame and no `stale` pulse.

Source files
------------

// File: rtl/serve_counters_if.sv
// Drop/clear handshake between the players, the serving counters and the scorer.
interface serve_counters_if;
    logic [1:0]      place_valid;
    logic [1:0]      place_space;
    logic [1:0][3:0] place_item;
    logic [1:0]      clear_space;
    logic [1:0][3:0] check_spaces;
    logic [1:0]      place_ack;
    logic [1:0]      stale;

    modport master (
        output place_valid, place_space, place_item, clear_space,
        input  check_spaces, place_ack, stale
    );

    modport slave (
        input  place_valid, place_space, place_item, clear_space,
        output check_spaces, place_ack, stale
    );
endinterface

// File: rtl/serve_counters.sv
// Two serving-window spaces: per-space empty/plate/dish FSM with stale-dish timeout.
// Optional reject display of invalid items is enabled by `SERVE_REJECT_EN.
module serve_counters #(
    parameter int unsigned STALE_FRAMES  = 600,
    parameter int unsigned REJECT_FRAMES = 30
) (
    input logic                vsync,
    input logic                reset_n,
    input logic [2:0]          game_state,
    serve_counters_if.slave    bus
);

    localparam logic [3:0] ItemPlate  = 4'd1;
    localparam logic [3:0] ItemSoup   = 4'd2;
    localparam logic [3:0] ItemPlated = 4'd4;

    // The 10-bit counter exits at limit-1, so limits above 1024 cannot be honoured.
    if (STALE_FRAMES == 0 || STALE_FRAMES > 1024 ||
        REJECT_FRAMES == 0 || REJECT_FRAMES > 1024) begin : g_bad_cfg
        $error("serve_counters: frame limits must lie in 1..1024");
    end

    localparam logic [9:0] StaleLast = 10'(STALE_FRAMES - 1);

    typedef enum logic [1:0] {
        StEmpty  = 2'd0,
        StPlate  = 2'd1,
`ifdef SERVE_REJECT_EN
        StDish   = 2'd2,
        StReject = 2'd3
`else
        StDish   = 2'd2
`endif
    } st_e;

`ifdef SERVE_REJECT_EN
    localparam logic [9:0] RejectLast = 10'(REJECT_FRAMES - 1);

    function automatic logic item_invalid(logic [3:0] item);
        return !(item inside {4'd0, ItemPlate, ItemSoup, ItemPlated});
    endfunction
`endif

    function automatic logic drop_ok(st_e st, logic [3:0] item);
        case (st)
`ifdef SERVE_REJECT_EN
            StEmpty: drop_ok = (item == ItemPlate) || (item == ItemPlated) || item_invalid(item);
`else
            StEmpty: drop_ok = (item == ItemPlate) || (item == ItemPlated);
`endif
            StPlate: drop_ok = (item == ItemSoup);
            default: drop_ok = 1'b0;
        endcase
    endfunction

    // Only meaningful when drop_ok() holds for the same arguments.
    function automatic st_e drop_next(st_e st, logic [3:0] item);
        if (st == StPlate)         return StDish;
        if (item == ItemPlate)     return StPlate;
        if (item == ItemPlated)    return StDish;
`ifdef SERVE_REJECT_EN
        return StReject;
`else
        return StEmpty;
`endif
    endfunction

    st_e        state_q [2];
    st_e        state_d [2];
    logic [9:0] cnt_q   [2];
    logic [9:0] cnt_d   [2];
    logic [1:0] ack_q, ack_d;
    logic [1:0] stale_q, stale_d;
    logic [1:0] tgt0, tgt1;

    assign tgt0 = bus.place_valid[0] ? (bus.place_space[0] ? 2'b10 : 2'b01) : 2'b00;
    assign tgt1 = bus.place_valid[1] ? (bus.place_space[1] ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        ack_d   = '0;
        stale_d = '0;
        for (int s = 0; s < 2; s++) begin
            state_d[s] = state_q[s];
            if (state_q[s] == StDish && bus.clear_space[s]) begin
                state_d[s] = StEmpty;
            end else if (tgt0[s] && drop_ok(state_q[s], bus.place_item[0])) begin
                state_d[s] = drop_next(state_q[s], bus.place_item[0]);
                ack_d[0]   = 1'b1;
            end else if (tgt1[s] && !tgt0[s] && drop_ok(state_q[s], bus.place_item[1])) begin
                // Player 1 loses the space outright whenever player 0 also targets it.
                state_d[s] = drop_next(state_q[s], bus.place_item[1]);
                ack_d[1]   = 1'b1;
            end else if (state_q[s] == StDish && cnt_q[s] == StaleLast) begin
                state_d[s] = StEmpty;
                stale_d[s] = 1'b1;
`ifdef SERVE_REJECT_EN
            end else if (state_q[s] == StReject && cnt_q[s] == RejectLast) begin
                state_d[s] = StEmpty;
`endif
            end

            if (state_d[s] != state_q[s]) begin
                cnt_d[s] = '0;
`ifdef SERVE_REJECT_EN
            end else if (state_q[s] == StDish || state_q[s] == StReject) begin
`else
            end else if (state_q[s] == StDish) begin
`endif
                cnt_d[s] = cnt_q[s] + 10'd1;
            end else begin
                cnt_d[s] = '0;
            end
        end
    end

    always_ff @(negedge vsync) begin
        if (!reset_n || game_state == 3'd0) begin
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= StEmpty;
                cnt_q[s]   <= '0;
            end
            ack_q   <= '0;
            stale_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= state_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            ack_q   <= ack_d;
            stale_q <= stale_d;
        end
    end

    assign bus.place_ack = ack_q;
    assign bus.stale     = stale_q;

    always_comb begin
        bus.check_spaces = '0;
        for (int s = 0; s < 2; s++) begin
            case (state_q[s])
                StPlate:  bus.check_spaces[s] = ItemPlate;
                StDish:   bus.check_spaces[s] = ItemPlated;
`ifdef SERVE_REJECT_EN
                StReject: bus.check_spaces[s] = 4'hF;
`endif
                default:  bus.check_spaces[s] = 4'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_serve_counters.sv
// Scoreboard bench for serve_counters: each frame pushes the expected outputs, then pops
// and compares them after the active (falling) vsync edge.
module tb_serve_counters;

    logic       vsync;
    logic       reset_n;
    logic [2:0] game_state;

    serve_counters_if bus ();

    serve_counters dut (
        .vsync      (vsync),
        .reset_n    (reset_n),
        .game_state (game_state),
        .bus        (bus)
    );

    initial vsync = 1'b1;
    always #5 vsync = ~vsync;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {check_spaces[1], check_spaces[0], place_ack, stale}.
    logic [11:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] sp, input logic [3:0] i0,
                        input logic [3:0] i1, input logic [1:0] clr, input logic [7:0] ec,
                        input logic [1:0] ea, input logic [1:0] es);
        logic [11:0] e;
        bus.place_valid   = v;
        bus.place_space   = sp;
        bus.place_item[0] = i0;
        bus.place_item[1] = i1;
        bus.clear_space   = clr;
        exp_q.push_back({ec, ea, es});
        @(negedge vsync);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("check_spaces", bus.check_spaces, e[11:4]);
            check_eq("place_ack", {6'd0, bus.place_ack}, {6'd0, e[3:2]});
            check_eq("stale", {6'd0, bus.stale}, {6'd0, e[1:0]});
        end
    endtask

    task automatic idle(input logic [7:0] ec, input logic [1:0] ea, input logic [1:0] es);
        step(2'b00, 2'b00, 4'd0, 4'd0, 2'b00, ec, ea, es);
    endtask

    initial begin
        reset_n          = 1'b0;
        game_state       = 3'd1;
        bus.place_valid  = '0;
        bus.place_space  = '0;
        bus.place_item   = '0;
        bus.clear_space  = '0;

        idle(8'h00, 2'b00, 2'b00);
        idle(8'h00, 2'b00, 2'b00);
        reset_n = 1'b1;

        // Plate, then soup, then the scorer clears two frames after the dish appears.
        step(2'b01, 2'b00, 4'd1, 4'd0, 2'b00, 8'h01, 2'b01, 2'b00);
        step(2'b01, 2'b00, 4'd2, 4'd0, 2'b00, 8'h04, 2'b01, 2'b00);
        idle(8'h04, 2'b00, 2'b00);
        step(2'b00, 2'b00, 4'd0, 4'd0, 2'b01, 8'h00, 2'b00, 2'b00);
        // Soup pot on an empty space is ignored.
        step(2'b01, 2'b00, 4'd2, 4'd0, 2'b00, 8'h00, 2'b00, 2'b00);

        // Both players on space 1: player 0 wins; player 1 retries on space 0.
        step(2'b11, 2'b11, 4'd4, 4'd4, 2'b00, 8'h40, 2'b01, 2'b00);
        step(2'b10, 2'b00, 4'd0, 4'd4, 2'b00, 8'h44, 2'b10, 2'b00);
        step(2'b01, 2'b00, 4'd1, 4'd0, 2'b00, 8'h44, 2'b00, 2'b00);
        step(2'b00, 2'b00, 4'd0, 4'd0, 2'b11, 8'h00, 2'b00, 2'b00);

        // Different spaces are both serviced; clear and wrong items on PLATE are ignored.
        step(2'b11, 2'b10, 4'd1, 4'd1, 2'b00, 8'h11, 2'b11, 2'b00);
        step(2'b11, 2'b10, 4'd4, 4'd2, 2'b01, 8'h41, 2'b10, 2'b00);

        // Menu wipes everything, including the dish on space 1, without a stale pulse.
        game_state = 3'd0;
        idle(8'h00, 2'b00, 2'b00);
        game_state = 3'd1;
        idle(8'h00, 2'b00, 2'b00);

        // Clear beats a simultaneous drop on a DISH space.
        step(2'b10, 2'b10, 4'd0, 4'd4, 2'b00, 8'h40, 2'b10, 2'b00);
        step(2'b10, 2'b10, 4'd0, 4'd4, 2'b10, 8'h00, 2'b00, 2'b00);

        // Uncollected dish goes stale on frame 600.
        step(2'b01, 2'b00, 4'd4, 4'd0, 2'b00, 8'h04, 2'b01, 2'b00);
        for (int j = 1; j < 600; j++) idle(8'h04, 2'b00, 2'b00);
        idle(8'h00, 2'b00, 2'b01);
        idle(8'h00, 2'b00, 2'b00);

        // Clear on frame 599 pre-empts the stale discard.
        step(2'b01, 2'b00, 4'd4, 4'd0, 2'b00, 8'h04, 2'b01, 2'b00);
        for (int j = 1; j < 599; j++) idle(8'h04, 2'b00, 2'b00);
        step(2'b00, 2'b00, 4'd0, 4'd0, 2'b01, 8'h00, 2'b00, 2'b00);
        idle(8'h00, 2'b00, 2'b00);

`ifdef SERVE_REJECT_EN
        // Invalid item shows 0xF for 30 frames; drops and clears meanwhile are ignored.
        step(2'b01, 2'b00, 4'd7, 4'd0, 2'b00, 8'h0F, 2'b01, 2'b00);
        for (int j = 1; j < 30; j++) begin
            if (j == 3)      step(2'b10, 2'b00, 4'd0, 4'd1, 2'b00, 8'h0F, 2'b00, 2'b00);
            else if (j == 5) step(2'b00, 2'b00, 4'd0, 4'd0, 2'b01, 8'h0F, 2'b00, 2'b00);
            else             idle(8'h0F, 2'b00, 2'b00);
        end
        idle(8'h00, 2'b00, 2'b00);
`else
        step(2'b01, 2'b00, 4'd7, 4'd0, 2'b00, 8'h00, 2'b00, 2'b00);
        idle(8'h00, 2'b00, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
